// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and select sequencer for the shared 8:1 mux (mux_8).
// Grants one requester at a time, enforces a maximum hold time while others
// wait, and inserts one dead cycle between grants (break-before-make).
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   en       - arbitration enable; low blocks new grants and timeout preemption
//   req[7:0] - request per mux input
//   gnt[7:0] - one-hot grant (registered), or zero
//   sel[2:0] - mux select index (registered): sel[2]=s2, sel[1]=s1, sel[0]=s0
//   valid    - mux output carries the granted source this cycle (registered)
//   preempt  - one-cycle pulse in the gap following a timeout revocation
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       preempt
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned HW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic          preempt_q, preempt_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic          found;
  logic          others;
  logic          at_max;

  // First set request searching ptr, ptr+1, ... ptr+7 (mod 8)
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_q + IW'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign others = |(req & ~(N'(1) << sel_q));
  assign at_max = (hold_q == HW'(MAX_HOLD));

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if (en && (|req)) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = N'(1) << win;
          hold_d  = HW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          // Release wins over timeout on the same edge
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = sel_q + IW'(1);
        end else if (en && at_max && others) begin
          state_d   = GAP;
          gnt_d     = '0;
          ptr_d     = sel_q + IW'(1);
          preempt_d = 1'b1;
        end else begin
          hold_d = at_max ? hold_q : hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    valid_d = (state_d == GRANT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign valid   = valid_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed testbench for mux8_rr_arbiter (MAX_HOLD = 4).
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       preempt;

  int checks;
  int failures;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] eg, input logic [2:0] es,
                         input logic ev, input logic ep);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".sel"}, 8'(sel), 8'(es));
    chk({tag, ".valid"}, 8'(valid), 8'(ev));
    chk({tag, ".preempt"}, 8'(preempt), 8'(ep));
  endtask

  initial begin
    int k;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    req      = 8'h00;

    tick();
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single requester 3
    req = 8'h08;
    tick(); chk_out("single_gnt", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk_out("single_gap", 8'h00, 3'd3, 1'b0, 1'b0);
    tick(); chk_out("single_idle", 8'h00, 3'd3, 1'b0, 1'b0);
    // ptr should now be 4: with req 0 and 4 pending, 4 wins
    req = 8'h11;
    tick(); chk_out("ptr4_gnt", 8'h10, 3'd4, 1'b1, 1'b0);

    // Asynchronous reset mid-grant
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h01;
    rst_n = 1'b1;
    tick(); chk_out("post_rst_gnt", 8'h01, 3'd0, 1'b1, 1'b0);

    // Round-robin order with all requesting, 2-cycle holds
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      k = n % 8;
      tick(); chk_out($sformatf("rr%0d_v1", n), 8'(1) << k, 3'(k), 1'b1, 1'b0);
      tick(); chk_out($sformatf("rr%0d_v2", n), 8'(1) << k, 3'(k), 1'b1, 1'b0);
      req[k] = 1'b0;
      tick(); chk_out($sformatf("rr%0d_gap", n), 8'h00, 3'(k), 1'b0, 1'b0);
      if (n < 8) req[k] = 1'b1;
    end
    req = 8'h00;
    tick(); chk_out("rr_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Timeout: req[2] held, req[5] arrives during the grant
    req = 8'h04;
    tick(); chk_out("to_h1", 8'h04, 3'd2, 1'b1, 1'b0);
    tick(); chk_out("to_h2", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h24;
    tick(); chk_out("to_h3", 8'h04, 3'd2, 1'b1, 1'b0);
    tick(); chk_out("to_h4", 8'h04, 3'd2, 1'b1, 1'b0);
    tick(); chk_out("to_gap", 8'h00, 3'd2, 1'b0, 1'b1);
    tick(); chk_out("to_next", 8'h20, 3'd5, 1'b1, 1'b0);
    tick(); chk_out("to_next2", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h04;
    tick(); chk_out("to_rel_gap", 8'h00, 3'd5, 1'b0, 1'b0);
    tick(); chk_out("to_regrant", 8'h04, 3'd2, 1'b1, 1'b0);

    // Release on the same edge as timeout: no preempt
    req = 8'h44;
    tick(); chk_out("sim_h2", 8'h04, 3'd2, 1'b1, 1'b0);
    tick(); chk_out("sim_h3", 8'h04, 3'd2, 1'b1, 1'b0);
    tick(); chk_out("sim_h4", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h40;
    tick(); chk_out("sim_gap", 8'h00, 3'd2, 1'b0, 1'b0);
    tick(); chk_out("sim_next", 8'h40, 3'd6, 1'b1, 1'b0);

    // Wrap: release 6 so ptr=7, then 7 beats 0
    req = 8'h00;
    tick(); chk_out("wrap_gap", 8'h00, 3'd6, 1'b0, 1'b0);
    req = 8'h81;
    tick(); chk_out("wrap_g7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h01;
    tick(); chk_out("wrap_gap2", 8'h00, 3'd7, 1'b0, 1'b0);
    tick(); chk_out("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);

    // en low: current grant continues past MAX_HOLD without preemption
    en  = 1'b0;
    req = 8'h03;
    for (int n = 0; n < 5; n++) begin
      tick(); chk_out($sformatf("en0_hold%0d", n), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    req = 8'h02;
    tick(); chk_out("en0_gap", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); chk_out("en0_idle1", 8'h00, 3'd0, 1'b0, 1'b0);
    tick(); chk_out("en0_idle2", 8'h00, 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk_out("en1_gnt", 8'h02, 3'd1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
